// File: rtl/idecoder_pkg.sv
// ============================================================================
// Module : idecoder_pkg
// Brief  : Shared JCOND codes, control-field offsets and decoder state type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package idecoder_pkg;

  localparam logic [2:0] c_JNONE   = 3'd0;
  localparam logic [2:0] c_JZ      = 3'd1;
  localparam logic [2:0] c_JNZ     = 3'd2;
  localparam logic [2:0] c_JN      = 3'd3;
  localparam logic [2:0] c_JNN     = 3'd4;
  localparam logic [2:0] c_JC      = 3'd5;
  localparam logic [2:0] c_JNC     = 3'd6;
  localparam logic [2:0] c_JALWAYS = 3'd7;

  // Offsets of the control fields relative to the control base bit.
  localparam int c_OFS_WRDTA = 0;
  localparam int c_OFS_WRGPR = 1;
  localparam int c_OFS_WRSFR = 2;
  localparam int c_OFS_WRMLR = 3;
  localparam int c_OFS_SGPRI = 4;
  localparam int c_OFS_SAOUT = 6;
  localparam int c_OFS_UAZRO = 9;
  localparam int c_OFS_UIMMB = 10;
  localparam int c_OFS_JCOND = 11;
  localparam int c_OFS_HALT  = 14;
  localparam int c_CTL_BITS  = 15;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } decState_t;

  function automatic int ctlBase(input int immw, input int rw);
    return immw + 2 * rw;
  endfunction

  function automatic int fieldPos(input int immw, input int rw, input int ofs);
    return ctlBase(immw, rw) + ofs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/idecoder_pipe_jcond_eval.sv
// ============================================================================
// Module : jcond_eval
// Brief  : Combinational jump-condition check of JCOND against {C, N, Z}.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jcond_eval
  import idecoder_pkg::*;
(
  input  logic [2:0] iJCOND,
  input  logic [2:0] iFLAGS,
  output logic       oTAKEN
);

  logic w_carry;
  logic w_neg;
  logic w_zero;

  assign {w_carry, w_neg, w_zero} = iFLAGS;

  always_comb begin
    oTAKEN = 1'b0;
    case (iJCOND)
      c_JNONE:   oTAKEN = 1'b0;
      c_JZ:      oTAKEN = w_zero;
      c_JNZ:     oTAKEN = ~w_zero;
      c_JN:      oTAKEN = w_neg;
      c_JNN:     oTAKEN = ~w_neg;
      c_JC:      oTAKEN = w_carry;
      c_JNC:     oTAKEN = ~w_carry;
      c_JALWAYS: oTAKEN = 1'b1;
      default:   oTAKEN = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/idecoder_pipe.sv
// ============================================================================
// Module : idecoder_pipe
// Brief  : Registered instruction decoder with valid/ready stages, conditional
//          jump resolution, branch-shadow squash and HALT/resume.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idecoder_pipe
  import idecoder_pkg::*;
#(
  parameter int IW     = 32,
  parameter int RW     = 4,
  parameter int IMMW   = 8,
  parameter int SHADOW = 1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [IW-1:0]   iINST,
  input  logic            iIVLD,
  output logic            oIRDY,
  input  logic [2:0]      iFLAGS,
  input  logic            iRESUME,
  output logic            oDVLD,
  input  logic            iDRDY,
  output logic            oWRDTA,
  output logic            oWRGPR,
  output logic            oWRSFR,
  output logic            oWRMLR,
  output logic            oUAZRO,
  output logic            oUIMMB,
  output logic [1:0]      oSGPRI,
  output logic [2:0]      oSAOUT,
  output logic [RW-1:0]   oSREGA,
  output logic [RW-1:0]   oSREGB,
  output logic [RW-1:0]   oSSFRR,
  output logic [IMMW-1:0] oIMMBV,
  output logic            oPCJEN,
  output logic            oHALTD
);

  localparam int         c_CB       = ctlBase(IMMW, RW);
  localparam logic [2:0] c_SHADOW   = 3'(SHADOW);
  localparam logic [2:0] c_SHADOWM1 = 3'(SHADOW - 1);
  localparam logic       c_SQUASHEN = (SHADOW != 0);

  decState_t       r_state;
  logic            r_dvld;
  logic            r_wrdta, r_wrgpr, r_wrsfr, r_wrmlr, r_uazro, r_uimmb;
  logic [1:0]      r_sgpri;
  logic [2:0]      r_saout;
  logic [RW-1:0]   r_srega, r_sregb;
  logic [IMMW-1:0] r_imm;
  logic [2:0]      r_jcond;
  logic            r_halt;
  logic [2:0]      r_squash;

  logic w_irdy, w_accept, w_handoff, w_taken, w_jump, w_squashNow, w_load;

  jcond_eval u_jcondEval (
    .iJCOND (r_jcond),
    .iFLAGS (iFLAGS),
    .oTAKEN (w_taken)
  );

  assign w_irdy    = (r_state == RUN) & (~r_dvld | iDRDY);
  assign w_accept  = iIVLD & w_irdy;
  // A reset cycle never counts as a handoff, so no jump can escape from it.
  assign w_handoff = r_dvld & iDRDY & ~iRST;
  assign w_jump    = w_handoff & w_taken;

  // The instruction accepted alongside a taken jump is the first shadow slot.
  assign w_squashNow = w_accept & (w_jump ? c_SQUASHEN : (r_squash != 3'd0));
  assign w_load      = w_accept & ~w_squashNow;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= RUN;
      r_dvld   <= 1'b0;
      r_wrdta  <= 1'b0;
      r_wrgpr  <= 1'b0;
      r_wrsfr  <= 1'b0;
      r_wrmlr  <= 1'b0;
      r_uazro  <= 1'b0;
      r_uimmb  <= 1'b0;
      r_sgpri  <= '0;
      r_saout  <= '0;
      r_srega  <= '0;
      r_sregb  <= '0;
      r_imm    <= '0;
      r_jcond  <= '0;
      r_halt   <= 1'b0;
      r_squash <= '0;
    end else begin
      if (w_load) begin
        r_imm   <= iINST[IMMW-1:0];
        r_sregb <= iINST[IMMW +: RW];
        r_srega <= iINST[IMMW+RW +: RW];
        r_wrdta <= iINST[c_CB + c_OFS_WRDTA];
        r_wrgpr <= iINST[c_CB + c_OFS_WRGPR];
        r_wrsfr <= iINST[c_CB + c_OFS_WRSFR];
        r_wrmlr <= iINST[c_CB + c_OFS_WRMLR];
        r_sgpri <= iINST[c_CB + c_OFS_SGPRI +: 2];
        r_saout <= iINST[c_CB + c_OFS_SAOUT +: 3];
        r_uazro <= iINST[c_CB + c_OFS_UAZRO];
        r_uimmb <= iINST[c_CB + c_OFS_UIMMB];
        r_jcond <= iINST[c_CB + c_OFS_JCOND +: 3];
        r_halt  <= iINST[c_CB + c_OFS_HALT];
      end

      if (w_load) begin
        r_dvld <= 1'b1;
      end else if (w_handoff) begin
        r_dvld <= 1'b0;
      end

      if (w_jump) begin
        r_squash <= !c_SQUASHEN ? 3'd0 : (w_accept ? c_SHADOWM1 : c_SHADOW);
      end else if (w_squashNow) begin
        r_squash <= r_squash - 3'd1;
      end

      case (r_state)
        RUN:     if (w_handoff && r_halt) r_state <= HALTED;
        HALTED:  if (iRESUME) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  generate
    if (IW > c_CB + c_CTL_BITS) begin : g_unusedHi
      logic w_unusedHi;
      assign w_unusedHi = ^iINST[IW-1:c_CB + c_CTL_BITS];
    end
  endgenerate

  assign oIRDY  = w_irdy;
  assign oDVLD  = r_dvld;
  assign oPCJEN = w_jump;
  assign oHALTD = (r_state == HALTED);
  assign oWRDTA = r_wrdta;
  assign oWRGPR = r_wrgpr;
  assign oWRSFR = r_wrsfr;
  assign oWRMLR = r_wrmlr;
  assign oUAZRO = r_uazro;
  assign oUIMMB = r_uimmb;
  assign oSGPRI = r_sgpri;
  assign oSAOUT = r_saout;
  assign oSREGA = r_srega;
  assign oSREGB = r_sregb;
  assign oSSFRR = r_sregb;
  assign oIMMBV = r_imm;

endmodule

`default_nettype wire

// File: tb/tb_idecoder_pipe.sv
// ============================================================================
// Module : tb_idecoder_pipe
// Brief  : Self-checking bench for idecoder_pipe (IW=32, RW=4, IMMW=8, SHADOW=1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idecoder_pipe;

  localparam int SHADOW = 1;

  logic        iCLK, iRST, iIVLD, oIRDY, iRESUME, oDVLD, iDRDY;
  logic [31:0] iINST;
  logic [2:0]  iFLAGS;
  logic        oWRDTA, oWRGPR, oWRSFR, oWRMLR, oUAZRO, oUIMMB, oPCJEN, oHALTD;
  logic [1:0]  oSGPRI;
  logic [2:0]  oSAOUT;
  logic [3:0]  oSREGA, oSREGB, oSSFRR;
  logic [7:0]  oIMMBV;

  int total = 0;
  int bad   = 0;

  idecoder_pipe #(.IW(32), .RW(4), .IMMW(8), .SHADOW(SHADOW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iINST(iINST), .iIVLD(iIVLD), .oIRDY(oIRDY),
    .iFLAGS(iFLAGS), .iRESUME(iRESUME), .oDVLD(oDVLD), .iDRDY(iDRDY),
    .oWRDTA(oWRDTA), .oWRGPR(oWRGPR), .oWRSFR(oWRSFR), .oWRMLR(oWRMLR),
    .oUAZRO(oUAZRO), .oUIMMB(oUIMMB), .oSGPRI(oSGPRI), .oSAOUT(oSAOUT),
    .oSREGA(oSREGA), .oSREGB(oSREGB), .oSSFRR(oSSFRR), .oIMMBV(oIMMBV),
    .oPCJEN(oPCJEN), .oHALTD(oHALTD)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic [34:0] gotF;
  assign gotF = {oWRDTA, oWRGPR, oWRSFR, oWRMLR, oUAZRO, oUIMMB, oSGPRI, oSAOUT,
                 oSREGA, oSREGB, oSSFRR, oIMMBV};

  // Expected outputs straight from the documented bit layout (CB = 16).
  function automatic logic [34:0] expF(input logic [31:0] i);
    return {i[16], i[17], i[18], i[19], i[25], i[26], i[21:20], i[24:22],
            i[15:12], i[11:8], i[11:8], i[7:0]};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] imm, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [10:0] ctl,
                                     input logic [2:0] jc, input logic halt);
    return {1'b0, halt, jc, ctl, ra, rb, imm};
  endfunction

  function automatic logic jt(input logic [2:0] jc, input logic [2:0] f);
    logic c, n, z;
    {c, n, z} = f;
    case (jc)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n;
      3'd4:    return !n;
      3'd5:    return c;
      3'd6:    return !c;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic doReset;
    iRST = 1'b1; iIVLD = 1'b0; iDRDY = 1'b0; iRESUME = 1'b0; iFLAGS = '0; iINST = '0;
    tick();
    iRST = 1'b0;
  endtask

  task automatic drain;
    iIVLD = 1'b0; iDRDY = 1'b1; iRESUME = 1'b0;
    tick(); tick();
  endtask

  task automatic jumpSeq(input logic z, input logic expPulse);
    logic [31:0] j, f1, f2;
    j  = mk(8'h11, 4'd1, 4'd2, 11'h003, 3'd1, 1'b0);
    f1 = mk(8'h22, 4'd4, 4'd5, 11'h108, 3'd0, 1'b0);
    f2 = mk(8'h33, 4'd6, 4'd8, 11'h250, 3'd0, 1'b0);
    iINST = j; iIVLD = 1'b1; iDRDY = 1'b1; iFLAGS = 3'b000;
    tick();
    iINST = f1; iFLAGS = {2'b00, z};
    @(negedge iCLK);
    chk("jmp_fields", gotF, expF(j));
    chk("jmp_pulse", oPCJEN, expPulse);
    tick();
    iINST = f2; iFLAGS = 3'b001;
    @(negedge iCLK);
    chk("jmp_f1_dvld", oDVLD, !expPulse);
    if (!expPulse) chk("jmp_f1_fields", gotF, expF(f1));
    chk("jmp_nopulse1", oPCJEN, 1'b0);
    tick();
    iIVLD = 1'b0;
    @(negedge iCLK);
    chk("jmp_f2_dvld", oDVLD, 1'b1);
    chk("jmp_f2_fields", gotF, expF(f2));
    tick();
    drain();
  endtask

  typedef struct {
    logic [2:0] jc;
    logic [2:0] flags;
    logic       taken;
  } jvec_t;

  jvec_t tbl[64];

  initial begin
    logic [31:0] ins[4];
    logic [31:0] a, b, h, x, y;
    logic [31:0] q[$];
    logic [31:0] e;
    int          skip;
    bit          halted, expDvld, expIrdy, handoff;

    for (int k = 0; k < 64; k++) begin
      tbl[k].jc    = 3'(k / 8);
      tbl[k].flags = 3'(k % 8);
      tbl[k].taken = jt(3'(k / 8), 3'(k % 8));
    end

    // Reset state
    doReset();
    @(negedge iCLK);
    chk("rst_dvld", oDVLD, 1'b0);
    chk("rst_halt", oHALTD, 1'b0);
    chk("rst_pcjen", oPCJEN, 1'b0);
    chk("rst_irdy", oIRDY, 1'b1);
    chk("rst_fields", gotF, 35'd0);
    tick();

    // Back-to-back stream
    ins[0] = mk(8'hA5, 4'd3, 4'd7, 11'h155, 3'd0, 1'b0);
    ins[1] = mk(8'h3C, 4'd9, 4'd1, 11'h2AA, 3'd0, 1'b0);
    ins[2] = mk(8'hFF, 4'd15, 4'd0, 11'h7FF, 3'd0, 1'b0);
    ins[3] = mk(8'h01, 4'd0, 4'd14, 11'h040, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      iIVLD = (k < 4); iINST = (k < 4) ? ins[k] : 32'd0; iDRDY = 1'b1;
      @(negedge iCLK);
      chk("b2b_irdy", oIRDY, 1'b1);
      chk("b2b_dvld", oDVLD, k != 0);
      if (k != 0) chk("b2b_fields", gotF, expF(ins[k-1]));
      tick();
    end
    @(negedge iCLK);
    chk("b2b_empty", oDVLD, 1'b0);
    tick();

    // Backpressure
    a = mk(8'h5A, 4'd2, 4'd11, 11'h0F0, 3'd0, 1'b0);
    b = mk(8'hC3, 4'd12, 4'd4, 11'h60F, 3'd0, 1'b0);
    iINST = a; iIVLD = 1'b1; iDRDY = 1'b0;
    tick();
    iINST = b;
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLK);
      chk("bp_irdy", oIRDY, 1'b0);
      chk("bp_dvld", oDVLD, 1'b1);
      chk("bp_hold", gotF, expF(a));
      tick();
    end
    iDRDY = 1'b1;
    @(negedge iCLK);
    chk("bp_release_irdy", oIRDY, 1'b1);
    tick();
    iIVLD = 1'b0;
    @(negedge iCLK);
    chk("bp_next", gotF, expF(b));
    chk("bp_next_dvld", oDVLD, 1'b1);
    tick();
    drain();

    // Jump with shadow squash, then not taken
    jumpSeq(1'b1, 1'b1);
    jumpSeq(1'b0, 1'b0);

    // JCOND x flags truth table
    foreach (tbl[k]) begin
      doReset();
      iINST = mk(8'(k), 4'd1, 4'd1, 11'h0, tbl[k].jc, 1'b0);
      iIVLD = 1'b1; iDRDY = 1'b0;
      tick();
      iIVLD = 1'b0; iFLAGS = tbl[k].flags; iDRDY = 1'b1;
      @(negedge iCLK);
      chk($sformatf("jtab_jc%0d_f%0d", tbl[k].jc, tbl[k].flags), oPCJEN, tbl[k].taken);
      tick();
    end

    // HALT and resume
    doReset();
    h = mk(8'h77, 4'd5, 4'd6, 11'h00F, 3'd0, 1'b1);
    x = mk(8'h99, 4'd10, 4'd13, 11'h301, 3'd0, 1'b0);
    iINST = h; iIVLD = 1'b1; iDRDY = 1'b1;
    tick();
    iIVLD = 1'b0;
    @(negedge iCLK);
    chk("halt_deliver", gotF, expF(h));
    chk("halt_not_yet", oHALTD, 1'b0);
    tick();
    iINST = x; iIVLD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge iCLK);
      chk("halt_haltd", oHALTD, 1'b1);
      chk("halt_irdy", oIRDY, 1'b0);
      chk("halt_dvld", oDVLD, 1'b0);
      tick();
    end
    iRESUME = 1'b1;
    @(negedge iCLK);
    chk("resume_cycle_irdy", oIRDY, 1'b0);
    tick();
    iRESUME = 1'b0;
    @(negedge iCLK);
    chk("resume_haltd", oHALTD, 1'b0);
    chk("resume_irdy", oIRDY, 1'b1);
    tick();
    iIVLD = 1'b0;
    @(negedge iCLK);
    chk("resume_deliver", gotF, expF(x));
    tick();
    drain();

    // Reset with a held jump instruction: no pulse in the reset cycle
    doReset();
    iINST = mk(8'h44, 4'd3, 4'd3, 11'h0, 3'd7, 1'b0); iIVLD = 1'b1; iDRDY = 1'b0;
    tick();
    iIVLD = 1'b0; iDRDY = 1'b1; iRST = 1'b1;
    @(negedge iCLK);
    chk("rstmid_nopulse", oPCJEN, 1'b0);
    tick();
    iRST = 1'b0;
    @(negedge iCLK);
    chk("rstmid_dvld", oDVLD, 1'b0);
    chk("rstmid_halt", oHALTD, 1'b0);

    // Reset with the squash counter loaded: next instruction must not be squashed
    y = mk(8'hE7, 4'd8, 4'd9, 11'h4A1, 3'd0, 1'b0);
    iINST = mk(8'h45, 4'd3, 4'd3, 11'h0, 3'd7, 1'b0); iIVLD = 1'b1; iDRDY = 1'b1;
    tick();
    iIVLD = 1'b0;
    @(negedge iCLK);
    chk("rstsq_pulse", oPCJEN, 1'b1);
    tick();
    iRST = 1'b1; iINST = y; iIVLD = 1'b1;
    tick();
    iRST = 1'b0;
    @(negedge iCLK);
    chk("rstsq_dvld0", oDVLD, 1'b0);
    chk("rstsq_irdy", oIRDY, 1'b1);
    tick();
    iIVLD = 1'b0;
    @(negedge iCLK);
    chk("rstsq_dvld1", oDVLD, 1'b1);
    chk("rstsq_fields", gotF, expF(y));
    tick();

    // Randomized traffic against a transaction-level model
    doReset();
    q.delete(); skip = 0; halted = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      iIVLD   = ($urandom_range(0, 3) != 0);
      iINST   = $urandom;
      if ($urandom_range(0, 9) != 0) iINST[30] = 1'b0;
      iDRDY   = ($urandom_range(0, 3) != 0);
      iFLAGS  = 3'($urandom_range(0, 7));
      iRESUME = ($urandom_range(0, 3) == 0);
      @(negedge iCLK);
      expDvld = (q.size() != 0);
      expIrdy = !halted && (!expDvld || iDRDY);
      chk("rnd_dvld", oDVLD, expDvld);
      chk("rnd_irdy", oIRDY, expIrdy);
      chk("rnd_haltd", oHALTD, halted);
      handoff = expDvld && iDRDY;
      if (handoff) begin
        e = q.pop_front();
        chk("rnd_fields", gotF, expF(e));
        chk("rnd_pcjen", oPCJEN, jt(e[29:27], iFLAGS));
        if (jt(e[29:27], iFLAGS)) skip = SHADOW;
      end else begin
        chk("rnd_nopulse", oPCJEN, 1'b0);
      end
      if (iIVLD && expIrdy) begin
        if (skip > 0) skip--;
        else q.push_back(iINST);
      end
      if (halted) begin
        if (iRESUME) halted = 0;
      end else if (handoff && e[30]) begin
        halted = 1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
